// File: rtl/hit_encoder_if.sv
// rtl/hit_encoder_if.sv - frame/draw-request inputs and hit event outputs of hit_encoder
interface hit_encoder_if;
   logic       start_of_frame;
   logic       player_dr;
   logic       life_dr;
   logic       coin_dr;
   logic       good_dr;
   logic       bad_dr;
   logic [2:0] hit_type;
   logic       busy;
   logic       invuln;

   modport master (
      output start_of_frame, player_dr, life_dr, coin_dr, good_dr, bad_dr,
      input  hit_type, busy, invuln
   );

   modport slave (
      input  start_of_frame, player_dr, life_dr, coin_dr, good_dr, bad_dr,
      output hit_type, busy, invuln
   );
endinterface

// File: rtl/hit_encoder.sv
// rtl/hit_encoder.sv - per-frame overlap recorder replaying hit_type pulses; optional HIT_INVULN_EN
module hit_encoder #(
   parameter int BAD_OVERRIDES = 1,
   parameter int INVULN_FRAMES = 60
) (
   input  logic         clk,
   input  logic         resetN,
   hit_encoder_if.slave bus
);
   typedef enum logic {COLLECT, EMIT} state_t;

   // flag bit positions inside the pend/emit vectors
   localparam int LIFE = 0;
   localparam int COIN = 1;
   localparam int GOOD = 2;
   localparam int BAD  = 3;

   state_t     state, state_next;
   logic [3:0] pend, pend_next;
   logic [3:0] emit, emit_next;
   logic [3:0] ovl, snap, src, pick;
   logic [2:0] hit_q, hit_next;
   logic       invuln_act;

   if (INVULN_FRAMES < 1 || INVULN_FRAMES > 255) begin : g_invuln_range
      $error("hit_encoder: INVULN_FRAMES must be 1..255");
   end

`ifdef HIT_INVULN_EN
   logic [7:0] cnt, cnt_next;

   assign invuln_act = (cnt != 8'd0);

   // reload on an emitted bad hit, otherwise count down once per frame boundary
   always_comb begin
      cnt_next = cnt;
      if (hit_next == 3'd4) begin
         cnt_next = 8'(INVULN_FRAMES);
      end else if (bus.start_of_frame && cnt != 8'd0) begin
         cnt_next = cnt - 8'd1;
      end
   end

   // invulnerability frame counter
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) cnt <= 8'd0;
      else         cnt <= cnt_next;
   end
`else
   assign invuln_act = 1'b0;
`endif

   // overlap capture, frame snapshot merge and priority pick of the next pulse
   always_comb begin
      ovl        = {bus.bad_dr, bus.good_dr, bus.coin_dr, bus.life_dr} & {4{bus.player_dr}};
      snap       = pend;
      src        = 4'b0000;
      pick       = 4'b0000;
      hit_next   = 3'd0;
      state_next = state;
      pend_next  = pend | ovl;
      emit_next  = emit;

      if (invuln_act) begin
         ovl[BAD]       = 1'b0;
         pend_next[BAD] = pend[BAD];
         snap[BAD]      = 1'b0;
      end
      // a discarded bad flag has already been removed, so it cannot suppress good
      if (BAD_OVERRIDES != 0 && snap[BAD]) begin
         snap[GOOD] = 1'b0;
      end

      if (bus.start_of_frame || state == EMIT) begin
         src = bus.start_of_frame ? (emit | snap) : emit;
         if (src[BAD]) begin
            pick[BAD] = 1'b1;
            hit_next  = 3'd4;
         end else if (src[LIFE]) begin
            pick[LIFE] = 1'b1;
            hit_next   = 3'd1;
         end else if (src[COIN]) begin
            pick[COIN] = 1'b1;
            hit_next   = 3'd2;
         end else if (src[GOOD]) begin
            pick[GOOD] = 1'b1;
            hit_next   = 3'd3;
         end
         emit_next = src & ~pick;
      end

      if (bus.start_of_frame) begin
         // overlaps seen on the boundary cycle belong to the new frame
         pend_next  = ovl;
         state_next = EMIT;
      end else if (state == EMIT) begin
         state_next = (src != 4'b0000) ? EMIT : COLLECT;
      end
   end

   // state register
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state <= COLLECT;
      else         state <= state_next;
   end

   // pending/emit flags and registered hit_type
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         pend  <= 4'b0000;
         emit  <= 4'b0000;
         hit_q <= 3'd0;
      end else begin
         pend  <= pend_next;
         emit  <= emit_next;
         hit_q <= hit_next;
      end
   end

   assign bus.hit_type = hit_q;
   assign bus.busy     = (state == EMIT);
   assign bus.invuln   = invuln_act;
endmodule

// File: tb/tb_hit_encoder.sv
// tb/tb_hit_encoder.sv - table-driven and sequence checks of hit_encoder
module tb_hit_encoder;
   logic clk = 1'b0;
   logic resetN;
   logic sof, player, life, coin, good, bad;

   always #5 clk = ~clk;

   hit_encoder_if bus1();
   hit_encoder_if bus0();

   assign bus1.start_of_frame = sof;
   assign bus1.player_dr      = player;
   assign bus1.life_dr        = life;
   assign bus1.coin_dr        = coin;
   assign bus1.good_dr        = good;
   assign bus1.bad_dr         = bad;
   assign bus0.start_of_frame = sof;
   assign bus0.player_dr      = player;
   assign bus0.life_dr        = life;
   assign bus0.coin_dr        = coin;
   assign bus0.good_dr        = good;
   assign bus0.bad_dr         = bad;

   hit_encoder #(.BAD_OVERRIDES(1), .INVULN_FRAMES(2)) dut1 (.clk(clk), .resetN(resetN), .bus(bus1));
   hit_encoder #(.BAD_OVERRIDES(0), .INVULN_FRAMES(2)) dut0 (.clk(clk), .resetN(resetN), .bus(bus0));

   typedef struct {
      logic [3:0]  frame;   // {bad,good,coin,life} overlaps during the frame
      logic [3:0]  at_sof;  // overlaps on the start_of_frame cycle
      logic [14:0] hits1;   // 5 post-SOF hit_type values, first in MSBs (BAD_OVERRIDES=1)
      logic [4:0]  busy1;
      logic [14:0] hits0;   // same for BAD_OVERRIDES=0
      logic [4:0]  busy0;
   } vec_t;

   vec_t        vecs [6];
   int          checks = 0;
   int          failures = 0;
   logic [14:0] h1, h0;
   logic [4:0]  b1, b0;
   logic [11:0] fh1, fh0, exp_fh;
   logic [3:0]  fi1, exp_fi;
   logic [2:0]  acc;

   function automatic logic [14:0] hs(input int a, input int b, input int c, input int d, input int e);
      return {3'(a), 3'(b), 3'(c), 3'(d), 3'(e)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic cycle(input logic s, input logic p, input logic [3:0] m);
      sof    = s;
      player = p;
      {bad, good, coin, life} = m;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetN = 1'b0;
      cycle(1'b0, 1'b0, 4'b0000);
      resetN = 1'b1;
      cycle(1'b0, 1'b0, 4'b0000);
   endtask

   task automatic collect();
      h1 = '0; h0 = '0; b1 = '0; b0 = '0;
      for (int j = 0; j < 5; j++) begin
         h1 = {h1[11:0], bus1.hit_type};
         h0 = {h0[11:0], bus0.hit_type};
         b1 = {b1[3:0], bus1.busy};
         b0 = {b0[3:0], bus0.busy};
         cycle(1'b0, 1'b0, 4'b0000);
      end
   endtask

   initial begin
      vecs[0] = '{4'b0010, 4'b0000, hs(2,0,0,0,0), 5'b10000, hs(2,0,0,0,0), 5'b10000};
      vecs[1] = '{4'b1111, 4'b0000, hs(4,1,2,0,0), 5'b11100, hs(4,1,2,3,0), 5'b11110};
      vecs[2] = '{4'b0000, 4'b0010, hs(0,0,0,0,0), 5'b10000, hs(0,0,0,0,0), 5'b10000};
      vecs[3] = '{4'b0000, 4'b0000, hs(2,0,0,0,0), 5'b10000, hs(2,0,0,0,0), 5'b10000};
      vecs[4] = '{4'b0101, 4'b0000, hs(1,3,0,0,0), 5'b11000, hs(1,3,0,0,0), 5'b11000};
      vecs[5] = '{4'b1100, 4'b0000, hs(4,0,0,0,0), 5'b10000, hs(4,3,0,0,0), 5'b11000};

      resetN = 1'b0;
      sof = 1'b0; player = 1'b0; {bad, good, coin, life} = 4'b0000;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_hit",    32'(bus1.hit_type), 32'd0);
      check("rst_busy",   32'(bus1.busy),     32'd0);
      check("rst_invuln", 32'(bus1.invuln),   32'd0);
      resetN = 1'b1;
      cycle(1'b0, 1'b0, 4'b0000);
      check("idle_hit",    32'(bus0.hit_type), 32'd0);
      check("idle_busy",   32'(bus0.busy),     32'd0);
      check("idle_invuln", 32'(bus0.invuln),   32'd0);

      // table: frame overlaps, boundary cycle, then five post-SOF samples
      for (int v = 0; v < 6; v++) begin
         for (int c = 0; c < 4; c++) cycle(1'b0, 1'b1, vecs[v].frame);
         cycle(1'b1, |vecs[v].at_sof, vecs[v].at_sof);
         collect();
         check($sformatf("v%0d_hits1", v), 32'(h1), 32'(vecs[v].hits1));
         check($sformatf("v%0d_busy1", v), 32'(b1), 32'(vecs[v].busy1));
         check($sformatf("v%0d_hits0", v), 32'(h0), 32'(vecs[v].hits0));
         check($sformatf("v%0d_busy0", v), 32'(b0), 32'(vecs[v].busy0));
         for (int c = 0; c < 2; c++) cycle(1'b0, 1'b0, 4'b0000);
      end

      // start_of_frame arriving mid-EMIT merges the new bad with the remaining good
      do_reset();
      for (int c = 0; c < 4; c++) cycle(1'b0, 1'b1, 4'b0111);
      cycle(1'b1, 1'b0, 4'b0000);
      h1 = {12'd0, bus1.hit_type}; h0 = {12'd0, bus0.hit_type};
      b1 = {4'd0, bus1.busy};      b0 = {4'd0, bus0.busy};
      cycle(1'b0, 1'b1, 4'b1000);
      h1 = {h1[11:0], bus1.hit_type}; h0 = {h0[11:0], bus0.hit_type};
      b1 = {b1[3:0], bus1.busy};      b0 = {b0[3:0], bus0.busy};
      cycle(1'b1, 1'b0, 4'b0000);
      for (int j = 0; j < 3; j++) begin
         h1 = {h1[11:0], bus1.hit_type}; h0 = {h0[11:0], bus0.hit_type};
         b1 = {b1[3:0], bus1.busy};      b0 = {b0[3:0], bus0.busy};
         cycle(1'b0, 1'b0, 4'b0000);
      end
      check("merge_hits1", 32'(h1), 32'(hs(1,2,4,3,0)));
      check("merge_busy1", 32'(b1), 32'(5'b11110));
      check("merge_hits0", 32'(h0), 32'(hs(1,2,4,3,0)));
      check("merge_busy0", 32'(b0), 32'(5'b11110));

      // reset in the middle of a 4,1 emission
      do_reset();
      for (int c = 0; c < 4; c++) cycle(1'b0, 1'b1, 4'b1001);
      cycle(1'b1, 1'b0, 4'b0000);
      check("pre_rst_hit", 32'(bus1.hit_type), 32'd4);
      #2;
      resetN = 1'b0;
      #1;
      check("mid_rst_hit",  32'(bus1.hit_type), 32'd0);
      check("mid_rst_busy", 32'(bus1.busy),     32'd0);
      @(posedge clk); #1;
      resetN = 1'b1;
      acc = 3'd0;
      for (int j = 0; j < 5; j++) begin
         acc = acc | bus1.hit_type | bus0.hit_type;
         cycle(1'b0, 1'b0, 4'b0000);
      end
      check("post_rst_quiet", 32'(acc), 32'd0);
      check("post_rst_invuln", 32'(bus1.invuln), 32'd0);
      cycle(1'b1, 1'b0, 4'b0000);
      acc = 3'd0;
      for (int j = 0; j < 4; j++) begin
         acc = acc | bus1.hit_type | bus0.hit_type;
         cycle(1'b0, 1'b0, 4'b0000);
      end
      check("empty_sof_quiet", 32'(acc), 32'd0);

      // bad overlap in four consecutive frames
      do_reset();
      fh1 = '0; fh0 = '0; fi1 = '0;
      for (int f = 0; f < 4; f++) begin
         for (int c = 0; c < 4; c++) cycle(1'b0, 1'b1, 4'b1000);
         cycle(1'b1, 1'b0, 4'b0000);
         fh1 = {fh1[8:0], bus1.hit_type};
         fh0 = {fh0[8:0], bus0.hit_type};
         fi1 = {fi1[2:0], bus1.invuln};
         for (int c = 0; c < 2; c++) cycle(1'b0, 1'b0, 4'b0000);
      end
`ifdef HIT_INVULN_EN
      exp_fh = {3'd4, 3'd0, 3'd0, 3'd4};
      exp_fi = 4'b1101;
`else
      exp_fh = {3'd4, 3'd4, 3'd4, 3'd4};
      exp_fi = 4'b0000;
`endif
      check("bad_frames_hits1",   32'(fh1), 32'(exp_fh));
      check("bad_frames_hits0",   32'(fh0), 32'(exp_fh));
      check("bad_frames_invuln1", 32'(fi1), 32'(exp_fi));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
